// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: opcodes, instruction layout, sequencer state encoding
// and opcode-class helpers used by the phase sequencer.
package mu0_pkg;

    localparam int unsigned OP_W      = 4;
    localparam int unsigned OPERAND_W = 12;
    localparam int unsigned WORD_W    = OP_W + OPERAND_W;
    localparam int unsigned STATE_W   = 3;

    localparam logic [OP_W-1:0] OP_LDA = 4'h0;
    localparam logic [OP_W-1:0] OP_STA = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [OP_W-1:0] OP_JMP = 4'h4;
    localparam logic [OP_W-1:0] OP_JMI = 4'h5;
    localparam logic [OP_W-1:0] OP_JEQ = 4'h6;
    localparam logic [OP_W-1:0] OP_STP = 4'h7;
    localparam logic [OP_W-1:0] OP_LDI = 4'h8;
    localparam logic [OP_W-1:0] OP_LSL = 4'h9;
    localparam logic [OP_W-1:0] OP_LSR = 4'hA;

    localparam logic [STATE_W-1:0] S_STOP = 3'd0;
    localparam logic [STATE_W-1:0] S_FET  = 3'd1;
    localparam logic [STATE_W-1:0] S_EX1  = 3'd2;
    localparam logic [STATE_W-1:0] S_EX2  = 3'd3;
    localparam logic [STATE_W-1:0] S_HALT = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        ST_STOP = S_STOP,
        ST_FET  = S_FET,
        ST_EX1  = S_EX1,
        ST_EX2  = S_EX2,
        ST_HALT = S_HALT
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic [OPERAND_W-1:0] operand;
    } instr_t;

    // Memory-operand arithmetic/load ops need a second execute phase.
    function automatic logic needs_exec2(input logic [OP_W-1:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Opcodes above LSR are unassigned and execute as NOPs.
    function automatic logic is_illegal(input logic [OP_W-1:0] op);
        return op > OP_LSR;
    endfunction

endpackage

// File: rtl/mu0_wrap_counter.sv
// Free-running modulo-2^W event counter with synchronous clear.
module mu0_wrap_counter #(
    parameter int unsigned W = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         INC,
    output logic [W-1:0] COUNT
);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            COUNT <= '0;
        end else if (INC) begin
            COUNT <= COUNT + W'(1);
        end
    end

endmodule

// File: rtl/mu0_phase_sequencer.sv
// MU0 phase controller: one-hot FETCH/EXEC1/EXEC2 strobes, instruction register,
// run/stop/single-step control, sticky halt/illegal flags and perf counters.
module mu0_phase_sequencer
    import mu0_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned RESET_RUN = 0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 RUN,
    input  logic                 STEP,
    input  logic [WORD_W-1:0]    MEM_DATA,
    output logic                 FETCH,
    output logic                 EXEC1,
    output logic                 EXEC2,
    output logic [OP_W-1:0]      OP,
    output logic [OPERAND_W-1:0] OPERAND,
    output logic                 STOPPED,
    output logic                 HALTED,
    output logic                 ILLEGAL,
    output logic [CNT_W-1:0]     CYCLE_COUNT,
    output logic [CNT_W-1:0]     INSTR_COUNT
);

    state_t          state;
    state_t          state_nxt;
    instr_t          ir;
    logic            step_mode;
    logic            start_run;
    logic            resume;
    logic            boundary;
    logic            stp_retire;
    logic            in_phase;
    logic [OP_W-1:0] op;

    // RUN is level-sampled every cycle, so RESET_RUN never changes the STOP exit.
    assign start_run  = RUN | ((RESET_RUN != 0) & RUN);
    assign resume     = RUN & ~step_mode;
    assign op         = ir.op;

    assign in_phase   = (state == ST_FET) || (state == ST_EX1) || (state == ST_EX2);
    assign stp_retire = (state == ST_EX1) && (op == OP_STP);
    assign boundary   = (state == ST_EX2)
                      || ((state == ST_EX1) && !needs_exec2(op) && (op != OP_STP));

    assign OP      = ir.op;
    assign OPERAND = ir.operand;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_STOP: begin
                if (start_run || STEP) begin
                    state_nxt = ST_FET;
                end
            end
            ST_FET: begin
                state_nxt = ST_EX1;
            end
            ST_EX1: begin
                if (op == OP_STP) begin
                    state_nxt = ST_HALT;
                end else if (needs_exec2(op)) begin
                    state_nxt = ST_EX2;
                end else begin
                    state_nxt = resume ? ST_FET : ST_STOP;
                end
            end
            ST_EX2: begin
                state_nxt = resume ? ST_FET : ST_STOP;
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_STOP;
            end
        endcase
    end

    // Strobes and status flags are registered decodes of the next state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_STOP;
            ir        <= '0;
            step_mode <= 1'b0;
            FETCH     <= 1'b0;
            EXEC1     <= 1'b0;
            EXEC2     <= 1'b0;
            STOPPED   <= 1'b1;
            HALTED    <= 1'b0;
            ILLEGAL   <= 1'b0;
        end else begin
            state   <= state_nxt;
            FETCH   <= (state_nxt == ST_FET);
            EXEC1   <= (state_nxt == ST_EX1);
            EXEC2   <= (state_nxt == ST_EX2);
            STOPPED <= (state_nxt == ST_STOP);
            HALTED  <= (state_nxt == ST_HALT);

            if (state == ST_FET) begin
                ir <= instr_t'(MEM_DATA);
            end

            if (state == ST_STOP) begin
                step_mode <= ~start_run & STEP;
            end else if (boundary) begin
                step_mode <= 1'b0;
            end

            if ((state == ST_EX1) && is_illegal(op)) begin
                ILLEGAL <= 1'b1;
            end
        end
    end

    mu0_wrap_counter #(.W(CNT_W)) u_cycle_count (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (in_phase),
        .COUNT (CYCLE_COUNT)
    );

    mu0_wrap_counter #(.W(CNT_W)) u_instr_count (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (boundary | stp_retire),
        .COUNT (INSTR_COUNT)
    );

endmodule

// File: tb/tb_mu0_phase_sequencer.sv
// Self-checking bench for mu0_phase_sequencer: directed scenarios plus random
// run/step/reset/memory traffic against an instruction-level reference model.
module tb_mu0_phase_sequencer;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned CNT_MASK = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             run;
    logic             step;
    logic [15:0]      mem_data;
    logic             fetch;
    logic             exec1;
    logic             exec2;
    logic [3:0]       op;
    logic [11:0]      operand;
    logic             stopped;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the current instruction (0 = idle).
    int          m_pos;
    bit          m_halt;
    bit          m_single;
    bit          m_ill;
    bit          m_fetched;
    logic [15:0] m_ir;
    int unsigned m_cyc;
    int unsigned m_ins;
    int          halt_cnt;

    mu0_phase_sequencer #(.CNT_W(CNT_W), .RESET_RUN(0)) dut (
        .CLK         (clk),
        .RESET       (reset),
        .RUN         (run),
        .STEP        (step),
        .MEM_DATA    (mem_data),
        .FETCH       (fetch),
        .EXEC1       (exec1),
        .EXEC2       (exec2),
        .OP          (op),
        .OPERAND     (operand),
        .STOPPED     (stopped),
        .HALTED      (halted),
        .ILLEGAL     (illegal),
        .CYCLE_COUNT (cycle_count),
        .INSTR_COUNT (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input logic [15:0] w, input bit rs);
        int op_v;
        int len;
        m_fetched = 1'b0;
        if (rs) begin
            m_pos = 0; m_halt = 0; m_single = 0; m_ill = 0;
            m_ir = '0; m_cyc = 0; m_ins = 0;
        end else if (m_halt) begin
            m_halt = 1'b1;
        end else if (m_pos == 0) begin
            if (r) begin
                m_pos = 1; m_single = 0;
            end else if (s) begin
                m_pos = 1; m_single = 1;
            end
        end else begin
            m_cyc++;
            if (m_pos == 1) begin
                m_ir = w; m_pos = 2; m_fetched = 1'b1;
            end else begin
                op_v = int'(m_ir[15:12]);
                len  = (op_v == 0 || op_v == 2 || op_v == 3) ? 3 : 2;
                if (m_pos == 2 && op_v == 7) begin
                    m_halt = 1; m_pos = 0; m_ins++;
                end else if (m_pos < len) begin
                    m_pos++;
                end else begin
                    m_ins++;
                    if (op_v >= 11) m_ill = 1;
                    if (m_single || !r) begin
                        m_pos = 0; m_single = 0;
                    end else begin
                        m_pos = 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        check("fetch",       32'(fetch),       32'(m_pos == 1));
        check("exec1",       32'(exec1),       32'(m_pos == 2));
        check("exec2",       32'(exec2),       32'(m_pos == 3));
        check("stopped",     32'(stopped),     32'(m_pos == 0 && !m_halt));
        check("halted",      32'(halted),      32'(m_halt));
        check("illegal",     32'(illegal),     32'(m_ill));
        check("op",          32'(op),          32'(m_ir[15:12]));
        check("operand",     32'(operand),     32'(m_ir[11:0]));
        check("cycle_count", 32'(cycle_count), m_cyc & CNT_MASK);
        check("instr_count", 32'(instr_count), m_ins & CNT_MASK);
    endtask

    // One clock: drive at the falling edge, model at the rising edge, compare at the next fall.
    task automatic tick(input bit r, input bit s, input logic [15:0] w, input bit rs);
        run = r; step = s; mem_data = w; reset = rs;
        @(posedge clk);
        model_step(r, s, w, rs);
        @(negedge clk);
        compare_all();
    endtask

    // Hold an instruction word on the bus until the sequencer has fetched it.
    task automatic exec(input logic [15:0] w, input bit r);
        for (int k = 0; k < 8; k++) begin
            tick(r, 1'b0, w, 1'b0);
            if (m_fetched) return;
        end
        check("exec_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [15:0] w;
        bit          r;
        bit          s;
        bit          rs;

        run = 0; step = 0; mem_data = '0; reset = 1;
        m_pos = 0; m_halt = 0; m_single = 0; m_ill = 0; m_fetched = 0;
        m_ir = '0; m_cyc = 0; m_ins = 0; halt_cnt = 0;
        @(negedge clk);

        // Reset state
        tick(0, 0, 16'h0000, 1);
        check("rst_stopped", 32'(stopped), 32'd1);
        check("rst_fetch",   32'(fetch),   32'd0);
        check("rst_cycles",  32'(cycle_count), 32'd0);

        // Free-run LDA, STA, JMP
        exec(16'h0005, 1);
        check("lda_op", 32'(op), 32'h0);
        exec(16'h1006, 1);
        check("sta_op", 32'(op), 32'h1);
        exec(16'h4000, 1);
        check("jmp_op", 32'(op), 32'h4);
        tick(0, 0, 16'h0000, 0);
        check("run3_cycles",  32'(cycle_count), 32'd7);
        check("run3_instrs",  32'(instr_count), 32'd3);
        check("run3_stopped", 32'(stopped),     32'd1);

        // Single step ADD; second STEP during EX1 is ignored
        tick(0, 0, 16'h0000, 1);
        tick(0, 1, 16'h2003, 0);
        tick(0, 0, 16'h2003, 0);
        tick(0, 1, 16'h0000, 0);
        check("step_exec2", 32'(exec2), 32'd1);
        tick(0, 0, 16'h0000, 0);
        tick(0, 0, 16'h0000, 0);
        check("step_stopped", 32'(stopped),     32'd1);
        check("step_instrs",  32'(instr_count), 32'd1);
        check("step_cycles",  32'(cycle_count), 32'd3);

        // STP halts until reset
        tick(0, 0, 16'h0000, 1);
        exec(16'h7000, 1);
        tick(1, 0, 16'h0000, 0);
        check("stp_halted", 32'(halted),      32'd1);
        check("stp_instrs", 32'(instr_count), 32'd1);
        for (int k = 0; k < 10; k++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 0);
            check("halt_hold",   32'(halted),      32'd1);
            check("halt_cycles", 32'(cycle_count), 32'd2);
        end
        tick(0, 0, 16'h0000, 1);
        check("halt_reset", 32'(halted), 32'd0);

        // Illegal opcode is a sticky 2-cycle NOP
        exec(16'hB123, 1);
        tick(1, 0, 16'h8001, 0);
        check("ill_fetch", 32'(fetch),   32'd1);
        check("ill_flag",  32'(illegal), 32'd1);
        exec(16'h8001, 1);
        exec(16'h2001, 1);
        tick(1, 0, 16'h0000, 0);
        check("ill_sticky", 32'(illegal), 32'd1);

        // Reset during EX2 of SUB
        tick(0, 0, 16'h0000, 1);
        exec(16'h3ABC, 1);
        tick(1, 0, 16'h0000, 0);
        check("sub_exec2", 32'(exec2), 32'd1);
        tick(1, 0, 16'h0000, 1);
        check("midrst_stopped", 32'(stopped), 32'd1);
        check("midrst_operand", 32'(operand), 32'd0);

        // Counter wrap with eight back-to-back LDI
        tick(0, 0, 16'h0000, 1);
        tick(1, 0, 16'h8001, 0);
        for (int k = 0; k < 15; k++) tick(1, 0, 16'h8001, 0);
        check("wrap_pre",   32'(cycle_count), 32'd15);
        tick(0, 0, 16'h8001, 0);
        check("wrap_cycles", 32'(cycle_count), 32'd0);
        check("wrap_instrs", 32'(instr_count), 32'd8);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 7) == 0);
            w = 16'($urandom);
            if (w[15:12] == 4'h7 && $urandom_range(0, 3) != 0) w[15:12] = 4'h2;
            rs = ($urandom_range(0, 199) == 0) || (halt_cnt > 12);
            tick(r, s, w, rs);
            if (m_halt) halt_cnt++;
            else        halt_cnt = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
